// File: rtl/inst_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U fields of an RV32I instruction word.
// Results queue in a 2-entry FIFO tagged with a sequential byte address and an error flag.
module inst_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    input  logic [2:0]        in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_J = 3'b011;
    localparam logic [2:0] SEL_U = 3'b100;

    logic [1:0]        count;
    logic [31:0]       tail_inst;
    logic [ADDR_W-1:0] tail_addr;
    logic              tail_err;
    logic [ADDR_W-1:0] next_addr;

    logic [31:0] mask;
    logic [31:0] fields;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        i_err;
    logic        b_err;
    logic        j_err;
    logic        u_err;
    logic        accept;
    logic        pop;

    // An immediate fits when every bit above the field's sign bit matches it.
    assign i_err = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
    assign b_err = in_imm[0] | ~((&in_imm[31:12]) | ~(|in_imm[31:12]));
    assign j_err = in_imm[0] | ~((&in_imm[31:20]) | ~(|in_imm[31:20]));
    assign u_err = ~((&in_imm[31:19]) | ~(|in_imm[31:19]));

    always_comb begin
        mask    = '0;
        fields  = '0;
        enc_err = 1'b0;
        case (in_sel)
            SEL_I: begin
                mask    = 32'hFFF0_0000;
                fields  = {in_imm[11:0], 20'b0};
                enc_err = i_err;
            end
            SEL_S: begin
                mask    = 32'hFE00_0F80;
                fields  = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                enc_err = i_err;
            end
            SEL_B: begin
                mask    = 32'hFE00_0F80;
                fields  = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                enc_err = b_err;
            end
            SEL_J: begin
                mask    = 32'hFFFF_F000;
                fields  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                enc_err = j_err;
            end
            SEL_U: begin
                mask    = 32'hFFFF_F000;
                fields  = {in_imm[19:0], 12'b0};
                enc_err = u_err;
            end
            default: begin
                mask    = '0;
                fields  = '0;
                enc_err = 1'b1;
            end
        endcase
        enc_inst = (in_base & ~mask) | fields;
    end

    assign out_valid = (count != 2'd0);
    assign in_ready  = (count < 2'd2) & ~restart;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head entry drives the outputs directly; the tail only holds a second word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            out_inst  <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            tail_inst <= '0;
            tail_addr <= '0;
            tail_err  <= 1'b0;
            next_addr <= BASE_ADDR;
        end else if (restart) begin
            count     <= 2'd0;
            next_addr <= BASE_ADDR;
        end else begin
            if (accept) begin
                next_addr <= next_addr + ADDR_W'(4);
            end
            case (count)
                2'd0: begin
                    if (accept) begin
                        out_inst <= enc_inst;
                        out_addr <= next_addr;
                        out_err  <= enc_err;
                        count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        out_inst <= enc_inst;
                        out_addr <= next_addr;
                        out_err  <= enc_err;
                    end else if (accept) begin
                        tail_inst <= enc_inst;
                        tail_addr <= next_addr;
                        tail_err  <= enc_err;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        out_inst <= tail_inst;
                        out_addr <= tail_addr;
                        out_err  <= tail_err;
                        count    <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && enc_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
